mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit for the multicycle CPU. Executes MULT/DIV
//   (one shift-add or restoring-subtract step per cycle) and owns the HI/LO
//   registers. hi_out/lo_out feed the writeback data mux for MFHI/MFLO.
//   The control unit issues start, stalls on busy, and traps on div_zero.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO are WIDTH bits each, product is 2*WIDTH
// PORTS
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   start      in   1      issue request, sampled only in IDLE
//   op         in   1      0 = multiply, 1 = divide
//   op_signed  in   1      1 = signed operands (honoured only with macro)
//   a          in   WIDTH  multiplicand / dividend, sampled with start
//   b          in   WIDTH  multiplier / divisor, sampled with start
//   busy       out  1      high from cycle after accepted start until done
//   done       out  1      1-cycle completion pulse
//   div_zero   out  1      sticky: last divide had b==0
//   hi_out     out  WIDTH  HI register (mult: product[63:32]; div: remainder)
//   lo_out     out  WIDTH  LO register (mult: product[31:0]; div: quotient)
// BEHAVIOUR
//   - Single clock domain; reset_n is asynchronous and active-low. Reset
//     (including mid-operation): state=IDLE; busy, done, div_zero,
//     hi_out, lo_out all 0; the in-flight operation is discarded.
//   - States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//     IDLE: start=1 latches a, b, op, and the magnitudes; counter=WIDTH-1;
//     clears div_zero. If op=1 and b==0, go to DONE; otherwise go to RUN.
//     RUN: one step per cycle for exactly WIDTH cycles; go to FIX at count 0.
//     FIX: apply sign correction; write HI/LO at the end of this cycle.
//     DONE: done=1 for this one cycle; go to IDLE.
//   - Timing: start accepted in cycle C0 => busy=1 during C0+1..C0+WIDTH+1,
//     done=1 in C0+WIDTH+2 with new HI/LO visible that same cycle.
//     busy=0 in DONE, so the next start is accepted no earlier than C0+WIDTH+3.
//   - start while busy or in DONE: ignored, no effect.
//   - Divide by zero: done=1 and div_zero=1 in C0+1; HI/LO unchanged;
//     div_zero holds until the next accepted start or reset.
//   - Multiply: {hi,lo} = full 2*WIDTH-bit product, never truncated.
//   - Divide: quotient truncates toward zero; remainder takes the dividend's
//     sign; |remainder| < |divisor|.
//   - Signed overflow -2^(W-1) / -1: lo=0x80000000, hi=0, no flag.
//   - hi_out/lo_out change only at the end of FIX or on reset.
// CONFIGURATION
//   MULTDIV_SIGNED_EN defined: op_signed=1 selects two's-complement operation
//     (operand abs in IDLE, result negate in FIX).
//   Not defined: op_signed is ignored; all operations are unsigned; FIX
//     passes results through; latency is unchanged.
// STRUCTURE
//   mdu_pkg: state enum {IDLE,RUN,FIX,DONE}, OP_MULT/OP_DIV encodings,
//     MDU_WIDTH default, counter-width constant $clog2(WIDTH).
//   Sub-module mdu_sign_fix (combinational): conditional two's-complement
//     negate of product/quotient/remainder; instantiated only under the macro.
//   Top level holds the FSM, counter, the {acc,q} shift register, and HI/LO.
// TESTING
//   1. Unsigned mult a=0xFFFFFFFF, b=0xFFFFFFFF -> done at C0+34,
//      hi=0xFFFFFFFE, lo=0x00000001.
//   2. Div a=100, b=7 -> hi=2, lo=14; busy high for exactly 33 cycles.
//   3. Div b=0 after a valid op -> done and div_zero at C0+1; HI/LO keep old
//      values; next start clears div_zero.
//   4. [SIGNED_EN] div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//      mult -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1;
//      0x80000000 / -1 -> lo=0x80000000, hi=0.
//   5. start pulsed every cycle during RUN -> ignored; only one done pulse;
//      result matches the first operands.
//   6. reset_n low at C0+10 of a mult -> all outputs 0 immediately; start
//      accepted in the first cycle after release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM state
// encodings, operation encodings, default width and counter width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  // FSM state encodings (plain constants so legacy code can reuse them)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Operation select encodings
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign correction for the multiply/divide unit. The iterative
// core works on magnitudes; this block restores two's-complement signs:
// product negated when operand signs differ, quotient likewise, remainder
// takes the dividend's sign. Only built when MULTDIV_SIGNED_EN is defined.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             op,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [WIDTH-1:0] hi_mag,
  input  logic [WIDTH-1:0] lo_mag,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] neg_prod;

  assign neg_prod = -{hi_mag, lo_mag};

  // Select negated or pass-through halves depending on operation and signs
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hi_res = hi_mag;
    lo_res = lo_mag;
    if (op == OP_MULT) begin
      if (sign_a ^ sign_b) begin
        hi_res = neg_prod[2*WIDTH-1:WIDTH];
        lo_res = neg_prod[WIDTH-1:0];
      end
    end else begin
      if (sign_a ^ sign_b) lo_res = -lo_mag;
      if (sign_a)          hi_res = -hi_mag;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the multicycle CPU.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle over
// a shared {acc,q} shift register; WIDTH steps, then a FIX cycle writes HI/LO
// and a DONE cycle pulses done. Divide by zero skips straight to DONE.
// Optional feature: define MULTDIV_SIGNED_EN to honour op_signed
// (magnitudes taken on issue, signs restored in FIX); otherwise unsigned only.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;       // partial product high half / partial remainder
  logic [WIDTH-1:0] q;         // multiplier being consumed / quotient being built
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic             op_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             accept;

  assign accept = (state == ST_IDLE) && start;

`ifdef MULTDIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic sign_a_r;
  logic sign_b_r;

  assign neg_a = op_signed & a[WIDTH-1];
  assign neg_b = op_signed & b[WIDTH-1];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  // Remember operand signs for the correction applied in FIX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
    end else if (accept) begin
      sign_a_r <= neg_a;
      sign_b_r <= neg_b;
    end
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op     (op_r),
    .sign_a (sign_a_r),
    .sign_b (sign_b_r),
    .hi_mag (acc),
    .lo_mag (q),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign mag_a  = a;
  assign mag_b  = b;
  assign hi_res = acc;
  assign lo_res = q;
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    acc_nxt = acc;
    q_nxt   = q;
    if (op_r == OP_MULT) begin
      sum     = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end else begin
      shifted = {acc, q[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Control FSM, iteration datapath and HI/LO result registers
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      acc        <= '0;
      q          <= '0;
      opnd       <= '0;
      op_r       <= OP_MULT;
      div_zero_r <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r       <= op;
            acc        <= '0;
            q          <= mag_a;
            opnd       <= mag_b;
            count      <= CNT_W'(WIDTH - 1);
            div_zero_r <= (op == OP_DIV) && (b == '0);
            state      <= ((op == OP_DIV) && (b == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          if (count == '0) state <= ST_FIX;
          else             count <= count - CNT_W'(1);
        end
        ST_FIX: begin
          hi_r  <= hi_res;
          lo_r  <= lo_res;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_RUN) || (state == ST_FIX);
  assign done     = (state == ST_DONE);
  assign div_zero = div_zero_r;
  assign hi_out   = hi_r;
  assign lo_out   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, busy window,
// multiply/divide results, divide-by-zero stickiness, start spam and
// mid-operation reset. Signed vectors apply when MULTDIV_SIGNED_EN is defined.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         op;
  logic         op_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int compared   = 0;
  int mismatched = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. lat counts cycles from
  // the accepting cycle C0 to the done cycle; bc counts busy cycles seen;
  // dz1 is div_zero observed in C0+1.
  task automatic run_op(input logic o, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, output int lat, output int bc,
                        output logic dz1);
    op = o; op_signed = s; a = av; b = bv; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    bc  = 0;
    dz1 = div_zero;
    while (!done && lat < 100) begin
      if (busy) bc++;
      tick;
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    int   lat;
    int   bc;
    int   extra;
    logic dz1;

    reset_n = 1'b0; start = 1'b0; op = 1'b0; op_signed = 1'b0; a = '0; b = '0;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz",   div_zero, 0);
    check("rst_hi",   hi_out, 0);
    check("rst_lo",   lo_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick;

    // 1. unsigned max * max
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz1);
    check("t1_lat",  lat, 34);
    check("t1_busy", bc, 33);
    check("t1_hi",   hi_out, 32'hFFFF_FFFE);
    check("t1_lo",   lo_out, 32'h0000_0001);
    check("t1_busy_in_done", busy, 0);
    tick;

    // 2. divide 100 / 7
    run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, bc, dz1);
    check("t2_lat",  lat, 34);
    check("t2_busy", bc, 33);
    check("t2_hi",   hi_out, 2);
    check("t2_lo",   lo_out, 14);
    tick;

    // 3. divide by zero keeps HI/LO, flag sticky until next start
    run_op(1'b1, 1'b0, 32'd5, 32'd0, lat, bc, dz1);
    check("t3_lat",  lat, 1);
    check("t3_busy", bc, 0);
    check("t3_dz",   div_zero, 1);
    check("t3_hi",   hi_out, 2);
    check("t3_lo",   lo_out, 14);
    tick;
    check("t3_dz_sticky", div_zero, 1);
    run_op(1'b0, 1'b0, 32'd3, 32'd5, lat, bc, dz1);
    check("t3_dz_cleared", dz1, 0);
    check("t3_mul_hi", hi_out, 0);
    check("t3_mul_lo", lo_out, 15);
    tick;

    // Unsigned divide boundaries
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, lat, bc, dz1);
    check("bd1_hi", hi_out, 0);
    check("bd1_lo", lo_out, 32'hFFFF_FFFF);
    tick;
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz1);
    check("bd2_hi", hi_out, 32'h8000_0000);
    check("bd2_lo", lo_out, 0);
    tick;
    run_op(1'b1, 1'b0, 32'd6, 32'd7, lat, bc, dz1);
    check("bd3_hi", hi_out, 6);
    check("bd3_lo", lo_out, 0);
    tick;

`ifdef MULTDIV_SIGNED_EN
    // 4. signed operations
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, dz1);
    check("s_div_lat", lat, 34);
    check("s_div_hi", hi_out, 32'hFFFF_FFFF);
    check("s_div_lo", lo_out, 32'hFFFF_FFFD);
    tick;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat, bc, dz1);
    check("s_mul_hi", hi_out, 32'hFFFF_FFFF);
    check("s_mul_lo", lo_out, 32'hFFFF_FFF1);
    tick;
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz1);
    check("s_ovf_hi", hi_out, 0);
    check("s_ovf_lo", lo_out, 32'h8000_0000);
    check("s_ovf_dz", div_zero, 0);
    tick;
`else
    // op_signed ignored: same vectors give unsigned results
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, dz1);
    check("u_div_lat", lat, 34);
    check("u_div_hi", hi_out, 1);
    check("u_div_lo", lo_out, 32'h7FFF_FFFC);
    tick;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat, bc, dz1);
    check("u_mul_hi", hi_out, 4);
    check("u_mul_lo", lo_out, 32'hFFFF_FFF1);
    tick;
`endif

    // 5. start held high through RUN/FIX/DONE with changing operands
    op = 1'b0; op_signed = 1'b0; a = 32'h1234_5678; b = 32'h0000_0010; start = 1'b1;
    tick;
    op = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    lat = 1;
    while (!done && lat < 100) begin
      tick;
      lat++;
    end
    check("spam_lat", lat, 34);
    check("spam_hi",  hi_out, 32'h0000_0001);
    check("spam_lo",  lo_out, 32'h2345_6780);
    tick;
    check("spam_not_accepted_in_done", busy, 0);
    start = 1'b0;
    extra = 0;
    repeat (5) begin
      tick;
      if (done) extra++;
    end
    check("spam_extra_done", extra, 0);
    check("spam_idle_busy", busy, 0);

    // 6. reset in the middle of a multiply
    op = 1'b0; a = 32'd7; b = 32'd6; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    check("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dz",   div_zero, 0);
    check("mid_rst_hi",   hi_out, 0);
    check("mid_rst_lo",   lo_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    op = 1'b0; a = 32'd9; b = 32'd11; start = 1'b1;
    tick;
    start = 1'b0;
    check("post_rst_accept", busy, 1);
    lat = 1;
    while (!done && lat < 100) begin
      tick;
      lat++;
    end
    check("post_rst_lat", lat, 34);
    check("post_rst_hi",  hi_out, 0);
    check("post_rst_lo",  lo_out, 99);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
